// File: rtl/exec_pkg.sv
// Shared constants for the execute/memory block: ALU control codes,
// the R-type ALUOp marker and MIPS function-field encodings.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;
  localparam logic [3:0] ALU_BAD  = 4'b1111;

  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// ALU-control decoder: passes non-R-type ALUOp straight through and
// decodes the function field for R-type instructions.
module alu_ctrl_decoder
  import exec_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic [5:0] func,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = alu_op;
    if (alu_op == ALUOP_RTYPE) begin
      unique case (func)
        FN_SLL:  alu_ctrl = ALU_SLL;
        FN_SRL:  alu_ctrl = ALU_SRL;
        FN_SRA:  alu_ctrl = ALU_SRA;
        FN_ADD:  alu_ctrl = ALU_ADD;
        FN_ADDU: alu_ctrl = ALU_ADDU;
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_SUBU: alu_ctrl = ALU_SUBU;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_XOR:  alu_ctrl = ALU_XOR;
        FN_NOR:  alu_ctrl = ALU_NOR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        FN_SLTU: alu_ctrl = ALU_SLTU;
        default: alu_ctrl = ALU_BAD;
      endcase
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory datapath: ALU-control decode, 32-bit ALU with Zero flag and
// a falling-edge data memory. Build option ALU_PRESHIFT_EN takes SRL from pre_shift.
module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int DATA_W    = 32,
  localparam int ADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              Reset_L,
  input  logic [3:0]        alu_op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] pre_shift,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] srlResult;
  logic [DATA_W-1:0] memArray [MEM_WORDS];

  alu_ctrl_decoder uDecoder (
    .alu_op  (alu_op),
    .func    (func),
    .alu_ctrl(alu_ctrl)
  );

`ifdef ALU_PRESHIFT_EN
  assign srlResult = pre_shift;
`else
  logic unusedPreShift;
  assign unusedPreShift = ^pre_shift;
  assign srlResult      = bus_b >> shamt;
`endif

  always_comb begin
    alu_out = '0;
    unique case (alu_ctrl)
      ALU_AND:  alu_out = bus_a & bus_b;
      ALU_OR:   alu_out = bus_a | bus_b;
      ALU_XOR:  alu_out = bus_a ^ bus_b;
      ALU_NOR:  alu_out = ~(bus_a | bus_b);
      ALU_ADD,
      ALU_ADDU: alu_out = bus_a + bus_b;
      ALU_SUB,
      ALU_SUBU: alu_out = bus_a - bus_b;
      ALU_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(bus_a) < $signed(bus_b))};
      ALU_SLTU: alu_out = {{(DATA_W-1){1'b0}}, (bus_a < bus_b)};
      ALU_SLL:  alu_out = bus_b << shamt;
      ALU_SRL:  alu_out = srlResult;
      ALU_SRA:  alu_out = $signed(bus_b) >>> shamt;
      ALU_LUI:  alu_out = {bus_b[15:0], 16'h0};
      default:  alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  // Falling-edge write lets a same-cycle read see the old word until mid-cycle.
  always_ff @(negedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < MEM_WORDS; i++) memArray[i] <= '0;
    end else if (mem_write) begin
      memArray[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? memArray[mem_addr] : '0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: table-driven ALU/decoder vectors
// followed by hand-written memory write/read/reset sequences.
module tb_exec_mem_unit;

  logic        clk;
  logic        Reset_L;
  logic [3:0]  alu_op;
  logic [5:0]  func;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [4:0]  shamt;
  logic [31:0] pre_shift;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  exec_mem_unit dut (
    .clk      (clk),
    .Reset_L  (Reset_L),
    .alu_op   (alu_op),
    .func     (func),
    .bus_a    (bus_a),
    .bus_b    (bus_b),
    .shamt    (shamt),
    .pre_shift(pre_shift),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .zero     (zero),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] pre;
    logic [3:0]  expCtrl;
    logic [31:0] expOut;
    logic        expZero;
  } alu_vec_t;

  alu_vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic mem_drive(input logic rd, input logic wr, input logic [5:0] addr,
                           input logic [31:0] data);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = data;
  endtask

  initial begin
    vecs[0]  = '{"add",     4'hF, 6'b100000, 32'd7,        32'd5,        5'd0, 32'h0,        4'b0010, 32'd12,       1'b0};
    vecs[1]  = '{"sub_eq",  4'hF, 6'b100010, 32'd5,        32'd5,        5'd0, 32'h0,        4'b0110, 32'd0,        1'b1};
    vecs[2]  = '{"slt_neg", 4'hF, 6'b101010, 32'hFFFFFFFF, 32'd1,        5'd0, 32'h0,        4'b0111, 32'd1,        1'b0};
    vecs[3]  = '{"sltu",    4'hF, 6'b101011, 32'hFFFFFFFF, 32'd1,        5'd0, 32'h0,        4'b1011, 32'd0,        1'b1};
    vecs[4]  = '{"nor",     4'hF, 6'b100111, 32'h0,        32'h0,        5'd0, 32'h0,        4'b1100, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{"sll",     4'hF, 6'b000000, 32'h0,        32'h80000010, 5'd4, 32'h08000001, 4'b0011, 32'h00000100, 1'b0};
    vecs[6]  = '{"sra",     4'hF, 6'b000011, 32'h0,        32'h80000010, 5'd4, 32'h08000001, 4'b1101, 32'hF8000001, 1'b0};
    vecs[7]  = '{"srl",     4'hF, 6'b000010, 32'h0,        32'h80000010, 5'd4, 32'h08000001, 4'b0100, 32'h08000001, 1'b0};
    vecs[8]  = '{"lui",     4'hE, 6'b000000, 32'h0,        32'h00001234, 5'd0, 32'h0,        4'b1110, 32'h12340000, 1'b0};
    vecs[9]  = '{"direct",  4'h2, 6'b100100, 32'd3,        32'd4,        5'd0, 32'h0,        4'b0010, 32'd7,        1'b0};
    vecs[10] = '{"badfn",   4'hF, 6'b111111, 32'd9,        32'd9,        5'd0, 32'h0,        4'b1111, 32'd0,        1'b1};
    vecs[11] = '{"and",     4'hF, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0,        4'b0000, 32'h0000F000, 1'b0};
    vecs[12] = '{"or",      4'hF, 6'b100101, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0,        4'b0001, 32'h0000FFF0, 1'b0};
    vecs[13] = '{"xor",     4'hF, 6'b100110, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0,        4'b1010, 32'h00000FF0, 1'b0};
    vecs[14] = '{"addu_wr", 4'hF, 6'b100001, 32'hFFFFFFFF, 32'd1,        5'd0, 32'h0,        4'b1000, 32'd0,        1'b1};
    vecs[15] = '{"subu_wr", 4'hF, 6'b100011, 32'd0,        32'd1,        5'd0, 32'h0,        4'b1001, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{"slt_pos", 4'hF, 6'b101010, 32'd1,        32'hFFFFFFFF, 5'd0, 32'h0,        4'b0111, 32'd0,        1'b1};

    Reset_L = 1'b0;
    alu_op = 4'h0; func = 6'h0; bus_a = '0; bus_b = '0; shamt = '0; pre_shift = '0;
    mem_drive(1'b0, 1'b0, 6'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 Reset_L = 1'b1;

    // reset state of memory
    @(posedge clk); #1;
    mem_drive(1'b1, 1'b0, 6'd0, 32'h0);
    #1 check("rst_addr0", mem_rdata, 32'h0);
    mem_drive(1'b1, 1'b0, 6'd63, 32'h0);
    #1 check("rst_addr63", mem_rdata, 32'h0);
    mem_drive(1'b0, 1'b0, 6'd0, 32'h0);

    // ALU / decoder vectors
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      alu_op = vecs[i].op; func = vecs[i].fn; bus_a = vecs[i].a;
      bus_b = vecs[i].b; shamt = vecs[i].sh; pre_shift = vecs[i].pre;
      #1;
      check({vecs[i].name, "_ctrl"}, {28'h0, alu_ctrl}, {28'h0, vecs[i].expCtrl});
      check({vecs[i].name, "_out"}, alu_out, vecs[i].expOut);
      check({vecs[i].name, "_zero"}, {31'h0, zero}, {31'h0, vecs[i].expZero});
    end

    // write DEADBEEF to addr 5 on a falling edge
    @(posedge clk); #1;
    mem_drive(1'b0, 1'b1, 6'd5, 32'hDEADBEEF);
    @(negedge clk); #1;
    mem_drive(1'b1, 1'b0, 6'd5, 32'h0);
    #1 check("rd_addr5", mem_rdata, 32'hDEADBEEF);
    mem_read = 1'b0;
    #1 check("rd_disabled", mem_rdata, 32'h0);
    mem_drive(1'b1, 1'b0, 6'd6, 32'h0);
    #1 check("rd_addr6", mem_rdata, 32'h0);

    // same-address read during write: old value before the falling edge
    @(posedge clk); #1;
    mem_drive(1'b1, 1'b1, 6'd7, 32'h11112222);
    #1 check("rw_old", mem_rdata, 32'h0);
    @(negedge clk); #1;
    check("rw_new", mem_rdata, 32'h11112222);
    mem_drive(1'b1, 1'b0, 6'd5, 32'h0);
    #1 check("rd5_again", mem_rdata, 32'hDEADBEEF);

    // asynchronous reset pulse between edges
    @(posedge clk); #2;
    Reset_L = 1'b0;
    #1 check("arst_addr5", mem_rdata, 32'h0);
    mem_addr = 6'd7;
    #1 check("arst_addr7", mem_rdata, 32'h0);
    #1 Reset_L = 1'b1;

    // write held across a falling edge while in reset is dropped
    @(posedge clk); #1;
    Reset_L = 1'b0;
    mem_drive(1'b0, 1'b1, 6'd9, 32'hCAFEF00D);
    @(negedge clk); #1;
    mem_drive(1'b0, 1'b0, 6'd9, 32'h0);
    Reset_L = 1'b1;
    mem_read = 1'b1;
    #1 check("rst_wr_blocked", mem_rdata, 32'h0);

    // writes work again after reset release
    @(posedge clk); #1;
    mem_drive(1'b1, 1'b1, 6'd9, 32'h5A5A0001);
    @(negedge clk); #1;
    mem_write = 1'b0;
    #1 check("post_rst_wr", mem_rdata, 32'h5A5A0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
